p23_uart_tx_fifo: RTL and testbench

P23_UART_TX_FIFO -- requirements
Module: p23_uart_tx_fifo

---
 rtl/p23_uart_tx_fifo_if.sv | 12 +
 rtl/p23_uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_p23_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p23_uart_tx_fifo_if.sv
// CPU-side request/acknowledge bus of the UART transmit FIFO.
interface p23_uart_tx_fifo_if;
  logic        valid;
  logic [3:0]  wstrb;
  logic        sel_status;
  logic [7:0]  wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, wstrb, sel_status, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, sel_status, wdata, output ready, rdata);
endinterface

// File: rtl/p23_uart_tx_fifo.sv
// Byte FIFO between a CPU bus and a UART transmitter; a drain FSM launches
// one byte per tx_valid pulse and holds off for a guard window.
module p23_uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  p23_uart_tx_fifo_if.slave    bus,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_GUARD, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] guard_cnt_q, guard_cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    mem_q [DEPTH];

  logic       empty, full, is_write, data_write, accept, push, pop;
  logic [7:0] level;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count      = wr_ptr_q - rd_ptr_q;
  assign level      = 8'(count);
  assign is_write   = |bus.wstrb;
  assign data_write = is_write && !bus.sel_status;
  // A data write into a full FIFO stalls even if a pop happens this cycle.
  assign accept     = bus.valid && !ready_q && !(data_write && full);
  assign push       = accept && data_write;

  always_comb begin
    ready_d  = accept;
    rdata_d  = '0;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    if (accept && !is_write) begin
      if (bus.sel_status) rdata_d = {16'b0, level, 6'b0, full, empty};
      else                rdata_d = {24'b0, DEPTH_B};
    end
  end

  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    tx_data_d   = tx_data_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          state_d   = S_LAUNCH;
          tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      S_LAUNCH: begin
        pop         = 1'b1;
        guard_cnt_d = '0;
        state_d     = (GUARD == 0) ? S_WAIT : S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt_q == CW'(GUARD - 1)) begin
          state_d     = S_WAIT;
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      guard_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign tx_valid  = (state_q == S_LAUNCH);
  assign tx_data   = tx_data_q;
endmodule

// File: tb/tb_p23_uart_tx_fifo.sv
// Scoreboard bench for p23_uart_tx_fifo: stimulus queues expected responses,
// a monitor scores bus acks and launched bytes against a counting model.
module tb_p23_uart_tx_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned GUARD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;

  p23_uart_tx_fifo_if bus_if();

  p23_uart_tx_fifo #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; } resp_t;  // 0 data wr, 1 ignored wr, 2 status rd, 3 data rd

  int          errors = 0, checks = 0;
  resp_t       resp_q[$];
  logic [7:0]  txexp_q[$];
  int unsigned tx_times[$];
  int unsigned n_push = 0, pops_total = 0, pops_prev = 0;
  int unsigned last_tx_cyc = 0, hold_left = 0;
  bit          have_last = 0, ready_prev = 0, mon_en = 0;
  logic [7:0]  last_byte = '0;
  int unsigned busy_len = 0, busy_rem = 0;
  bit          force_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transmitter model: busy for busy_len cycles starting one cycle after tx_valid.
  initial forever begin
    @(posedge clk); #2;
    if (busy_rem > 0) begin
      tx_busy = 1'b1;
      busy_rem--;
    end else begin
      tx_busy = force_busy;
    end
    if (tx_valid === 1'b1 && busy_len > 0) busy_rem = busy_len;
  end

  // Monitor: level at acceptance = writes acked earlier minus launches before the acceptance cycle.
  initial forever begin
    int unsigned pops_lag;
    int          lvl;
    resp_t       r;
    @(negedge clk);
    if (mon_en) begin
      pops_lag  = pops_prev;
      pops_prev = pops_total;
      if (bus_if.ready === 1'b1) begin
        check("ready_single_cycle", 32'(ready_prev), 32'd0);
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: ready=1 at cycle %0d, expected no ack", cyc);
        end else begin
          r = resp_q.pop_front();
          case (r.kind)
            0: n_push++;
            2: begin
              lvl = int'(n_push) - int'(pops_lag);
              check("status_rdata", bus_if.rdata,
                    {16'b0, 8'(lvl), 6'b0, (lvl == int'(DEPTH)), (lvl == 0)});
            end
            3: check("data_reg_rdata", bus_if.rdata, 32'(DEPTH));
            default: ;
          endcase
        end
      end else begin
        check("rdata_idle_zero", bus_if.rdata, 32'd0);
      end
      ready_prev = (bus_if.ready === 1'b1);
      if (tx_valid === 1'b1) begin
        if (txexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_launch: tx_valid with byte 0x%02h at cycle %0d, expected none", tx_data, cyc);
        end else begin
          check("tx_byte_order", 32'(tx_data), 32'(txexp_q.pop_front()));
        end
        if (have_last) begin
          checks++;
          if (cyc - last_tx_cyc < GUARD + 2) begin
            errors++;
            $display("FAIL tx_spacing: got %0d cycles, expected >= %0d", cyc - last_tx_cyc, GUARD + 2);
          end
        end
        have_last   = 1;
        last_tx_cyc = cyc;
        tx_times.push_back(cyc);
        pops_total++;
        last_byte = tx_data;
        hold_left = GUARD + 1;
      end else if (hold_left > 0) begin
        check("tx_data_stable", 32'(tx_data), 32'(last_byte));
        hold_left--;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_if.valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_q.delete(); txexp_q.delete();
    n_push = 0; pops_total = 0; pops_prev = 0;
    have_last = 0; hold_left = 0; ready_prev = 0;
    check("rst_ready", 32'(bus_if.ready), 32'd0);
    check("rst_rdata", bus_if.rdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    mon_en = 1;
  endtask

  task automatic bus_start(input bit wr, input bit sel, input logic [7:0] d);
    resp_t r;
    bus_if.valid      = 1'b1;
    bus_if.wstrb      = wr ? 4'($urandom_range(1, 15)) : 4'b0;
    bus_if.sel_status = sel;
    bus_if.wdata      = d;
    if (wr && !sel) begin
      r.kind = 0;
      txexp_q.push_back(d);
    end else if (wr) r.kind = 1;
    else if (sel)    r.kind = 2;
    else             r.kind = 3;
    resp_q.push_back(r);
  endtask

  task automatic bus_wait(input int limit, output bit ok, output logic [31:0] rd, output int unsigned rcyc);
    ok = 0; rd = '0; rcyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (bus_if.ready === 1'b1) begin
        ok = 1; rd = bus_if.rdata; rcyc = cyc;
        break;
      end
    end
    if (ok) bus_if.valid = 1'b0;
  endtask

  task automatic bus_xfer(input bit wr, input bit sel, input logic [7:0] d,
                          output logic [31:0] rd, output int unsigned rcyc);
    bit ok;
    bus_start(wr, sel, d);
    bus_wait(300, ok, rd, rcyc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bus_timeout: no ready within 300 cycles, expected ready");
      bus_if.valid = 1'b0;
      void'(resp_q.pop_back());
      if (wr && !sel) void'(txexp_q.pop_back());
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (txexp_q.size() == 0) begin done = 1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes never launched, expected 0", txexp_q.size());
    end
    idle(20);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int unsigned rc, rc1, rcw;
    bit ok, found;
    bus_if.valid = 1'b0; bus_if.wstrb = '0; bus_if.sel_status = 1'b0; bus_if.wdata = '0;

    do_reset();

    bus_xfer(0, 1, 8'h00, rd, rc); check("status_empty", rd, 32'h0000_0001);
    bus_xfer(0, 0, 8'h00, rd, rc); check("data_reg_read", rd, 32'(DEPTH));
    bus_xfer(1, 1, 8'h5A, rd, rc);
    bus_xfer(0, 1, 8'h00, rd, rc); check("status_after_ignored_wr", rd, 32'h0000_0001);

    // Fill while the transmitter is held busy, then stall one more write.
    force_busy = 1;
    for (int i = 0; i < 5; i++) bus_xfer(1, 0, 8'($urandom), rd, rc);
    bus_xfer(0, 1, 8'h00, rd, rc); check("status_level5", rd, 32'h0000_0500);
    for (int i = 5; i < int'(DEPTH); i++) bus_xfer(1, 0, 8'($urandom), rd, rc);
    bus_xfer(0, 1, 8'h00, rd, rc); check("status_full", rd, (32'(DEPTH) << 8) | 32'h2);
    bus_start(1, 0, 8'hEE);
    bus_wait(20, ok, rd, rc);
    check("stall_no_ready", 32'(ok), 32'd0);
    tx_times.delete();
    force_busy = 0;
    if (!ok) bus_wait(60, ok, rd, rc);
    check("stall_acked", 32'(ok), 32'd1);
    checks++;
    if (tx_times.size() == 0 || rc < tx_times[0] || rc - tx_times[0] > 3) begin
      errors++;
      $display("FAIL stall_ack_latency: ack cycle %0d, launches seen %0d, expected ack within 3 cycles of first pop",
               rc, tx_times.size());
    end
    wait_drain();

    // Three bytes against a 10-cycle busy transmitter.
    busy_len = 10;
    tx_times.delete();
    bus_xfer(1, 0, 8'h41, rd, rc1);
    bus_xfer(1, 0, 8'h42, rd, rc);
    bus_xfer(1, 0, 8'h43, rd, rc);
    wait_drain();
    check("launch_count_3", tx_times.size(), 32'd3);
    if (tx_times.size() >= 3) begin
      check("first_launch_latency", tx_times[0] - (rc1 - 1), 32'd2);
      check("gap_after_busy_1", tx_times[1] - tx_times[0], 32'd13);
      check("gap_after_busy_2", tx_times[2] - tx_times[1], 32'd13);
    end

    // Write landing on the LAUNCH pop cycle with three bytes queued.
    force_busy = 1;
    for (int i = 0; i < 3; i++) bus_xfer(1, 0, 8'($urandom), rd, rc);
    bus_xfer(0, 1, 8'h00, rd, rc); check("status_level3_pre", rd, 32'h0000_0300);
    tx_times.delete();
    force_busy = 0;
    @(posedge clk); #1;
    bus_start(1, 0, 8'hC3);
    bus_wait(300, ok, rd, rcw);
    check("push_pop_write_acked", 32'(ok), 32'd1);
    check("write_on_launch_cycle", (tx_times.size() > 0) ? tx_times[0] : 32'hFFFF_FFFF, rcw - 1);
    bus_xfer(0, 1, 8'h00, rd, rc); check("status_level3_post", rd, 32'h0000_0300);
    wait_drain();

    // Random byte streams with mixed bus traffic and busy lengths.
    for (int s = 0; s < 100; s++) begin
      busy_len = $urandom_range(0, 6);
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        int op;
        op = $urandom_range(0, 9);
        if (op < 7)       bus_xfer(1, 0, 8'($urandom), rd, rc);
        else if (op == 7) bus_xfer(0, 1, 8'h00, rd, rc);
        else if (op == 8) bus_xfer(0, 0, 8'h00, rd, rc);
        else              bus_xfer(1, 1, 8'($urandom), rd, rc);
        idle($urandom_range(0, 2));
      end
      if (s % 10 == 9) wait_drain();
    end

    // Continuous traffic through both pointer wraps.
    busy_len = 0;
    for (int i = 0; i < int'(3 * DEPTH + 5); i++) begin
      bus_xfer(1, 0, 8'($urandom), rd, rc);
      if (i % 4 == 3) bus_xfer(0, 1, 8'h00, rd, rc);
    end
    wait_drain();
    bus_xfer(0, 1, 8'h00, rd, rc); check("status_empty_after_wrap", rd, 32'h0000_0001);

    // Reset during GUARD with four bytes still queued.
    force_busy = 1;
    for (int i = 0; i < 5; i++) bus_xfer(1, 0, 8'($urandom), rd, rc);
    force_busy = 0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (tx_valid === 1'b1) begin found = 1; break; end
    end
    check("launch_before_reset", 32'(found), 32'd1);
    do_reset();
    idle(30);
    bus_xfer(0, 1, 8'h00, rd, rc); check("status_empty_after_reset", rd, 32'h0000_0001);
    tx_times.delete();
    bus_xfer(1, 0, 8'h99, rd, rc);
    wait_drain();
    check("launch_after_reset_write", tx_times.size(), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
